// File: rtl/stack_ctrl_pkg.sv
// Shared opcodes, state encoding and fault/ALU codes for the stack processor control unit.
// Imported by the decoder and the control unit top.
package stack_ctrl_pkg;

   localparam int OP_NOP    = 0;
   localparam int OP_PUSH_I = 1;
   localparam int OP_PUSH_M = 2;
   localparam int OP_POP_M  = 3;
   localparam int OP_ADD    = 4;
   localparam int OP_SUB    = 5;
   localparam int OP_AND    = 6;
   localparam int OP_OR     = 7;
   localparam int OP_JMP    = 8;
   localparam int OP_JZ     = 9;
   localparam int OP_HALT   = 15;

   localparam logic [1:0] FC_NONE      = 2'b00;
   localparam logic [1:0] FC_OVERFLOW  = 2'b01;
   localparam logic [1:0] FC_UNDERFLOW = 2'b10;
   localparam logic [1:0] FC_ILLEGAL   = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_READ1,
      ST_READ2,
      ST_EXEC,
      ST_WRITE,
      ST_HALT,
      ST_FAULT
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP,
      CLS_PUSH_I,
      CLS_PUSH_M,
      CLS_POP_M,
      CLS_ALU,
      CLS_JMP,
      CLS_JZ,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

endpackage

// File: rtl/stack_ctrl_decode.sv
// Combinational opcode classifier: instruction class, legality, minimum stack
// occupancy needed, net push/pop effect and ALU function select.
module stack_ctrl_decode
   import stack_ctrl_pkg::*;
#(
   parameter int OP_W = 5
) (
   input  logic [OP_W-1:0] op,
   output op_class_t       op_class,
   output logic            legal,
   output logic [1:0]      min_depth,
   output logic            pushes,
   output logic            pops,
   output logic [1:0]      alu_sel
);

   always_comb begin
      op_class  = CLS_ILLEGAL;
      legal     = 1'b1;
      min_depth = 2'd0;
      pushes    = 1'b0;
      pops      = 1'b0;
      alu_sel   = ALU_ADD;
      case (op)
         OP_W'(OP_NOP):    op_class = CLS_NOP;
         OP_W'(OP_PUSH_I): begin
            op_class = CLS_PUSH_I;
            pushes   = 1'b1;
         end
         OP_W'(OP_PUSH_M): begin
            op_class = CLS_PUSH_M;
            pushes   = 1'b1;
         end
         OP_W'(OP_POP_M): begin
            op_class  = CLS_POP_M;
            min_depth = 2'd1;
            pops      = 1'b1;
         end
         // Binary ops consume two entries and leave one: a net single pop.
         OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_OR): begin
            op_class  = CLS_ALU;
            min_depth = 2'd2;
            pops      = 1'b1;
            case (op[1:0])
               2'b00:   alu_sel = ALU_ADD;
               2'b01:   alu_sel = ALU_SUB;
               2'b10:   alu_sel = ALU_AND;
               default: alu_sel = ALU_OR;
            endcase
         end
         OP_W'(OP_JMP):  op_class = CLS_JMP;
         OP_W'(OP_JZ): begin
            op_class  = CLS_JZ;
            min_depth = 2'd1;
            pops      = 1'b1;
         end
         OP_W'(OP_HALT): op_class = CLS_HALT;
         default:        legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/stack_ctrl_unit.sv
// Multi-cycle control unit for the stack processor: fetch/decode/sequence of ROM,
// data RAM, stack RAM and external ALU, with overflow/underflow/illegal faults.
module stack_ctrl_unit
   import stack_ctrl_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 5,
   parameter int OP_W        = 5,
   parameter int STACK_DEPTH = 16,
   localparam int INST_W     = OP_W + ADDR_W,
   localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [SP_W-2:0]   stack_addr,
   output logic [DATA_W-1:0] stack_wdata,
   output logic              stack_wren,
   input  logic [DATA_W-1:0] stack_rdata,
   output logic [1:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_y,
   output logic [ADDR_W-1:0] pc,
   output logic [SP_W-1:0]   sp,
   output logic [OP_W-1:0]   opcode,
   output logic              halted,
   output logic              fault,
   output logic [1:0]        fault_code
);

   state_t            state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [SP_W-1:0]   sp_reg;
   logic [INST_W-1:0] ir_reg;
   logic [DATA_W-1:0] temp1_reg;
   logic              halted_reg;
   logic              fault_reg;
   logic [1:0]        fault_code_reg;

   // The ROM word is only valid during DECODE; later states work from the latched IR.
   logic [INST_W-1:0] inst_cur;
   logic [OP_W-1:0]   op_cur;
   logic [ADDR_W-1:0] operand_cur;
   logic [DATA_W-1:0] operand_ext;

   assign inst_cur    = (state_reg == ST_DECODE) ? rom_data : ir_reg;
   assign op_cur      = inst_cur[INST_W-1:ADDR_W];
   assign operand_cur = inst_cur[ADDR_W-1:0];
   assign operand_ext = DATA_W'(operand_cur);

   op_class_t  dec_class;
   logic       dec_legal;
   logic [1:0] dec_min_depth;
   logic       dec_pushes;
   logic       dec_pops;
   logic [1:0] dec_alu_sel;

   stack_ctrl_decode #(
      .OP_W (OP_W)
   ) u_decode (
      .op        (op_cur),
      .op_class  (dec_class),
      .legal     (dec_legal),
      .min_depth (dec_min_depth),
      .pushes    (dec_pushes),
      .pops      (dec_pops),
      .alu_sel   (dec_alu_sel)
   );

   logic [ADDR_W-1:0] pc_inc;
   logic [SP_W-1:0]   sp_dec;
   logic [SP_W-1:0]   sp_dec2;
   logic [SP_W-1:0]   sp_step;
   logic              sp_full;
   logic              sp_short;

   assign pc_inc   = pc_reg + ADDR_W'(1);
   assign sp_dec   = sp_reg - SP_W'(1);
   assign sp_dec2  = sp_reg - SP_W'(2);
   assign sp_step  = dec_pushes ? (sp_reg + SP_W'(1)) : (dec_pops ? sp_dec : sp_reg);
   assign sp_full  = (sp_reg == SP_W'(STACK_DEPTH));
   assign sp_short = (sp_reg < SP_W'(dec_min_depth));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_FETCH;
         pc_reg         <= '0;
         sp_reg         <= '0;
         ir_reg         <= '0;
         temp1_reg      <= '0;
         halted_reg     <= 1'b0;
         fault_reg      <= 1'b0;
         fault_code_reg <= FC_NONE;
      end else begin
         case (state_reg)
            ST_FETCH: begin
               if (run) begin
                  state_reg <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               ir_reg <= rom_data;
               if (!dec_legal) begin
                  state_reg      <= ST_FAULT;
                  fault_reg      <= 1'b1;
                  fault_code_reg <= FC_ILLEGAL;
               end else if (dec_pushes && sp_full) begin
                  state_reg      <= ST_FAULT;
                  fault_reg      <= 1'b1;
                  fault_code_reg <= FC_OVERFLOW;
               end else if (sp_short) begin
                  state_reg      <= ST_FAULT;
                  fault_reg      <= 1'b1;
                  fault_code_reg <= FC_UNDERFLOW;
               end else begin
                  case (dec_class)
                     CLS_NOP: begin
                        pc_reg    <= pc_inc;
                        state_reg <= ST_FETCH;
                     end
                     CLS_JMP: begin
                        pc_reg    <= operand_cur;
                        state_reg <= ST_FETCH;
                     end
                     CLS_HALT: begin
                        halted_reg <= 1'b1;
                        state_reg  <= ST_HALT;
                     end
                     CLS_PUSH_I: state_reg <= ST_WRITE;
                     default:    state_reg <= ST_READ1;
                  endcase
               end
            end
            ST_READ1: begin
               if (dec_class == CLS_ALU || dec_class == CLS_JZ) begin
                  state_reg <= ST_READ2;
               end else begin
                  state_reg <= ST_WRITE;
               end
            end
            ST_READ2: begin
               if (dec_class == CLS_JZ) begin
                  pc_reg    <= (stack_rdata == '0) ? operand_cur : pc_inc;
                  sp_reg    <= sp_step;
                  state_reg <= ST_FETCH;
               end else begin
                  temp1_reg <= stack_rdata;
                  state_reg <= ST_EXEC;
               end
            end
            ST_EXEC, ST_WRITE: begin
               pc_reg    <= pc_inc;
               sp_reg    <= sp_step;
               state_reg <= ST_FETCH;
            end
            ST_HALT:  state_reg <= ST_HALT;
            ST_FAULT: state_reg <= ST_FAULT;
            default:  state_reg <= ST_FAULT;
         endcase
      end
   end

   // Memory/ALU side is a pure function of state so read data can flow straight through.
   always_comb begin
      rom_addr    = '0;
      ram_addr    = '0;
      ram_wdata   = '0;
      ram_wren    = 1'b0;
      stack_addr  = '0;
      stack_wdata = '0;
      stack_wren  = 1'b0;
      alu_op      = ALU_ADD;
      alu_a       = '0;
      alu_b       = '0;
      if (!reset) begin
         rom_addr = pc_reg;
         case (state_reg)
            ST_READ1: begin
               if (dec_class == CLS_PUSH_M) begin
                  ram_addr = operand_cur;
               end else begin
                  stack_addr = sp_dec[SP_W-2:0];
               end
            end
            ST_READ2: begin
               if (dec_class == CLS_ALU) begin
                  stack_addr = sp_dec2[SP_W-2:0];
               end
            end
            ST_EXEC: begin
               alu_op      = dec_alu_sel;
               alu_a       = stack_rdata;
               alu_b       = temp1_reg;
               stack_addr  = sp_dec2[SP_W-2:0];
               stack_wdata = alu_y;
               stack_wren  = 1'b1;
            end
            ST_WRITE: begin
               if (dec_class == CLS_POP_M) begin
                  stack_addr = sp_dec[SP_W-2:0];
                  ram_addr   = operand_cur;
                  ram_wdata  = stack_rdata;
                  ram_wren   = 1'b1;
               end else begin
                  stack_addr  = sp_reg[SP_W-2:0];
                  stack_wdata = (dec_class == CLS_PUSH_M) ? ram_rdata : operand_ext;
                  stack_wren  = 1'b1;
                  if (dec_class == CLS_PUSH_M) begin
                     ram_addr = operand_cur;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign pc         = pc_reg;
   assign sp         = sp_reg;
   assign opcode     = ir_reg[INST_W-1:ADDR_W];
   assign halted     = halted_reg;
   assign fault      = fault_reg;
   assign fault_code = fault_code_reg;

endmodule

// File: doc/stack_ctrl_unit.md
# stack_ctrl_unit

Parametrised control unit for the stack-based processor: fetches instructions from ROM, decodes them, sequences the stack RAM, data RAM and external ALU, and maintains PC and stack pointer. Successor to the fixed 16-bit/5-bit control unit. Adds generic widths and depth, stack overflow/underflow and illegal-opcode detection with a sticky fault, a conditional jump, and a `run` gate. Sits between the instruction ROM, the two RAMs and the ALU in the processor top level.

## Interface
- `DATA_W`, 16, datapath width; must satisfy `DATA_W >= ADDR_W`
- `ADDR_W`, 5, ROM/RAM address width and operand field width
- `OP_W`, 5, opcode field width (≥4); `INST_W = OP_W + ADDR_W`
- `STACK_DEPTH`, 16, stack entries (power of 2); `SP_W = $clog2(STACK_DEPTH)+1`
- `clock` in 1: single clock; all state changes on its rising edge
- `reset` in 1: synchronous, active-high
- `run` in 1: permits leaving FETCH
- `rom_addr` out ADDR_W, `rom_data` in INST_W: synchronous ROM, 1-cycle read
- `ram_addr` out ADDR_W, `ram_wdata` out DATA_W, `ram_wren` out 1, `ram_rdata` in DATA_W: synchronous RAM, 1-cycle read
- `stack_addr` out SP_W-1, `stack_wdata` out DATA_W, `stack_wren` out 1, `stack_rdata` in DATA_W: stack RAM, 1-cycle read
- `alu_op` out 2 (00 add, 01 sub, 10 and, 11 or), `alu_a`/`alu_b` out DATA_W, `alu_y` in DATA_W: combinational ALU
- `pc` out ADDR_W, `sp` out SP_W, `opcode` out OP_W (latched IR field)
- `halted` out 1, `fault` out 1, `fault_code` out 2 (01 overflow, 10 underflow, 11 illegal)

## Operation
- Instruction: `opcode = inst[INST_W-1:ADDR_W]`, `operand = inst[ADDR_W-1:0]`, zero-extended to DATA_W.
- Opcodes: 0 NOP, 1 PUSH_I, 2 PUSH_M, 3 POP_M, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 JMP, 9 JZ, 15 HALT; all others illegal.
- `sp` = number of entries (0..STACK_DEPTH). Push writes `stack[sp]`, then `sp+1`; top-of-stack is `stack[sp-1]`.
- States: FETCH, DECODE, READ1, READ2, EXEC, WRITE, HALT, FAULT.
- FETCH: `rom_addr=pc`. If `run=1`, go to DECODE; otherwise hold with no side effects.
- DECODE: latch IR from `rom_data`. Fault checks have priority:
  - illegal opcode → FAULT, code 11;
  - PUSH_I/PUSH_M with `sp==STACK_DEPTH` → FAULT, code 01;
  - POP_M/JZ with `sp<1`, or ALU op with `sp<2` → FAULT, code 10.
- PUSH_I: DECODE → WRITE. WRITE asserts `stack_wren`, `stack_addr=sp`, `stack_wdata=operand`; then `sp+1`, `pc+1`.
- PUSH_M: READ1 drives `ram_addr=operand`. WRITE pushes `ram_rdata`.
- POP_M: READ1 drives `stack_addr=sp-1`. WRITE asserts `ram_wren`, `ram_addr=operand`, `ram_wdata=stack_rdata`; then `sp-1`, `pc+1`.
- ALU ops (4–7): READ1 drives `stack_addr=sp-1`. READ2 latches temp1 (b) and drives `stack_addr=sp-2`. EXEC drives `alu_a=stack_rdata`, `alu_b=temp1`, `alu_op=opcode[1:0]`, and writes `alu_y` to `stack[sp-2]`; then `sp-1`, `pc+1`. SUB computes a−b. Results are mod 2^DATA_W.
- JMP: `pc=operand` in DECODE.
- JZ: READ1 drives `stack_addr=sp-1`. READ2 pops; `pc = (stack_rdata==0) ? operand : pc+1`.
- NOP: `pc+1`. HALT: go to HALT and set `halted=1`.
- HALT and FAULT are terminal until `reset`. PC wraps modulo 2^ADDR_W.

## Timing
- Cycles per instruction: NOP/JMP 2, PUSH_I 3, PUSH_M/POP_M/JZ 4, ALU 5. `run=0` adds cycles in FETCH only.
- Reset values: `pc=0`, `sp=0`, state FETCH, IR=0, `halted=0`, `fault=0`, `fault_code=00`; all address/data outputs 0.
- Write enables are 1-cycle pulses, combinationally forced low while `reset=1`.
- Reset mid-instruction aborts it: no partial write and no pc/sp update.
- A faulting instruction performs no write and leaves `pc` and `sp` unchanged.
- `sp` and `pc` update at the end of the last cycle of the instruction.

## Structure
- Package `stack_ctrl_pkg`: opcode localparams, state enum, fault-code and `alu_op` constants.
- One sub-module, `stack_ctrl_decode`: combinational opcode → class, legality, stack requirement, push/pop flags.
- FSM, PC, SP, IR and temp1 live in the top module. The ALU stays external.

## Test plan
- DATA_W=16, ADDR_W=5, STACK_DEPTH=4, `run=1`. ROM: PUSH_I 7; PUSH_I 5; SUB; POP_M 3; HALT → RAM[3]=2, `sp=0`, `halted=1` from cycle 18 after reset release.
- ROM: ADD at pc 0 → `fault=1`, `fault_code=10`, no `stack_wren`, `pc=0`.
- Five PUSH_I 1 → 5th faults with `fault_code=01`, `sp=4`, stack contents unchanged.
- PUSH_I 0; JZ 6 → `pc=6`, `sp=0`. PUSH_I 1; JZ 6 → `pc=2`.
- PUSH_I 0; PUSH_I 1; SUB; POP_M 0 → RAM[0]=16'hFFFF (wrap). Opcode 12 → `fault_code=11`.
- Reset asserted during ALU EXEC → no `stack_wren`, `pc=0`, `sp=0` next cycle. `run=0` after reset → FETCH held, `pc=0`, no writes.
